// File: rtl/sensor_conditioner.sv
// Sensor front end for the traffic-light controller.
// Synchronises and debounces the pedestrian button and car loop, then
// latches them into requests that clear on the matching green acknowledge.
//
// Debouncer states:
//   state | meaning
//   S_LO  | debounced level is 0, input agrees
//   C_HI  | input went high, counting down before accepting it
//   S_HI  | debounced level is 1, input agrees
//   C_LO  | input went low, counting down before accepting it

module sensor_conditioner_deb #(
  parameter logic [31:0] DEB = 32'd4
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_in,
  output logic o_lvl
);

  typedef enum logic [1:0] {S_LO, C_HI, S_HI, C_LO} state_t;

  state_t      r_state, w_state_nxt;
  logic [31:0] r_count, w_count_nxt;
  logic        r_lvl,   w_lvl_nxt;

  // State, counter and debounced level registers.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= S_LO;
      r_count <= 32'd0;
      r_lvl   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_count <= w_count_nxt;
      r_lvl   <= w_lvl_nxt;
    end
  end

  // Next-state logic: a change must hold for DEB+1 samples to be accepted.
  always_comb begin
    w_state_nxt = r_state;
    w_count_nxt = r_count;
    w_lvl_nxt   = r_lvl;
    case (r_state)
      S_LO: if (i_in) begin
        w_state_nxt = C_HI;
        w_count_nxt = DEB - 32'd1;
      end
      C_HI: begin
        if (!i_in)                 w_state_nxt = S_LO;
        else if (r_count == 32'd0) begin
          w_state_nxt = S_HI;
          w_lvl_nxt   = 1'b1;
        end else                   w_count_nxt = r_count - 32'd1;
      end
      S_HI: if (!i_in) begin
        w_state_nxt = C_LO;
        w_count_nxt = DEB - 32'd1;
      end
      C_LO: begin
        if (i_in)                  w_state_nxt = S_HI;
        else if (r_count == 32'd0) begin
          w_state_nxt = S_LO;
          w_lvl_nxt   = 1'b0;
        end else                   w_count_nxt = r_count - 32'd1;
      end
      default: w_state_nxt = S_LO;
    endcase
  end

  assign o_lvl = r_lvl;

endmodule

module sensor_conditioner #(
  parameter logic        SIM    = 1'b0,
  parameter logic [31:0] DEB_HW = 32'd500000
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_ped_btn_raw,
  input  logic       i_car_loop_raw,
  input  logic       i_ped_green,
  input  logic       i_car_green,
  output logic       o_sensor_b,
  output logic       o_sensor_a,
  output logic       o_ped_wait_lamp,
  output logic [7:0] o_ped_req_count
);

  localparam logic [31:0] DEB = (SIM == 1'b0) ? DEB_HW : 32'd4;

  logic       r_ped_sync1, r_ped_sync2, r_car_sync1, r_car_sync2;
  logic       r_ped_lvl_q, r_ped_green_q, r_car_green_q;
  logic       r_sensor_b, r_sensor_a;
  logic [7:0] r_ped_req_count;
  logic       w_ped_lvl, w_car_lvl;
  logic       w_ped_set, w_ped_clr, w_car_set, w_car_clr;

  // Two-flop synchronisers for the asynchronous raw inputs.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_ped_sync1 <= 1'b0;
      r_ped_sync2 <= 1'b0;
      r_car_sync1 <= 1'b0;
      r_car_sync2 <= 1'b0;
    end else begin
      r_ped_sync1 <= i_ped_btn_raw;
      r_ped_sync2 <= r_ped_sync1;
      r_car_sync1 <= i_car_loop_raw;
      r_car_sync2 <= r_car_sync1;
    end
  end

  sensor_conditioner_deb #(.DEB(DEB)) u_ped_deb (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_in  (r_ped_sync2),
    .o_lvl (w_ped_lvl)
  );

  sensor_conditioner_deb #(.DEB(DEB)) u_car_deb (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_in  (r_car_sync2),
    .o_lvl (w_car_lvl)
  );

  // Pedestrian is edge-triggered; car is level-triggered. Clear wins.
  assign w_ped_set = w_ped_lvl & ~r_ped_lvl_q & ~i_ped_green;
  assign w_ped_clr = i_ped_green & ~r_ped_green_q;
  assign w_car_set = w_car_lvl & ~i_car_green;
  assign w_car_clr = i_car_green & ~r_car_green_q;

  // Edge-detect history, request latches and saturating press counter.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_ped_lvl_q     <= 1'b0;
      r_ped_green_q   <= 1'b0;
      r_car_green_q   <= 1'b0;
      r_sensor_b      <= 1'b0;
      r_sensor_a      <= 1'b0;
      r_ped_req_count <= 8'd0;
    end else begin
      r_ped_lvl_q   <= w_ped_lvl;
      r_ped_green_q <= i_ped_green;
      r_car_green_q <= i_car_green;
      if (w_ped_clr) begin
        r_sensor_b <= 1'b0;
      end else if (w_ped_set && !r_sensor_b) begin
        r_sensor_b <= 1'b1;
        if (r_ped_req_count != 8'hFF) r_ped_req_count <= r_ped_req_count + 8'd1;
      end
      if (w_car_clr)      r_sensor_a <= 1'b0;
      else if (w_car_set) r_sensor_a <= 1'b1;
    end
  end

  assign o_sensor_b      = r_sensor_b;
  assign o_sensor_a      = r_sensor_a;
  assign o_ped_wait_lamp = r_sensor_b;
  assign o_ped_req_count = r_ped_req_count;

endmodule

// File: tb/tb_sensor_conditioner.sv
// Directed and randomized bench for sensor_conditioner (SIM mode, DEB=4).
module tb_sensor_conditioner;

  localparam int DEB = 4;

  logic       clk = 1'b0;
  logic       rst, pb, cl, pg, cg;
  logic       sb, sa, lamp;
  logic [7:0] cnt;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: raw sample history, run lengths, request state.
  int ped_q[$];
  int car_q[$];
  bit m_pl, m_pl_d, m_cl;
  int p_run, c_run;
  bit m_pg_d, m_cg_d, m_sb, m_sa;
  int m_cnt;

  sensor_conditioner #(.SIM(1'b1), .DEB_HW(32'd500000)) dut (
    .i_clk           (clk),
    .i_rst           (rst),
    .i_ped_btn_raw   (pb),
    .i_car_loop_raw  (cl),
    .i_ped_green     (pg),
    .i_car_green     (cg),
    .o_sensor_b      (sb),
    .o_sensor_a      (sa),
    .o_ped_wait_lamp (lamp),
    .o_ped_req_count (cnt)
  );

  always #5 clk = ~clk;

  function automatic void mreset();
    ped_q.delete();
    car_q.delete();
    m_pl = 0; m_pl_d = 0; m_cl = 0;
    p_run = 0; c_run = 0;
    m_pg_d = 0; m_cg_d = 0; m_sb = 0; m_sa = 0;
    m_cnt = 0;
  endfunction

  // A level change is accepted once DEB+1 consecutive synchronised samples
  // disagree with the current level; synchronised sample = raw two edges ago.
  function automatic void model_edge();
    bit s2p, s2c;
    s2p = (ped_q.size() >= 2) ? (ped_q[ped_q.size()-2] != 0) : 1'b0;
    s2c = (car_q.size() >= 2) ? (car_q[car_q.size()-2] != 0) : 1'b0;
    ped_q.push_back(int'(pb));
    car_q.push_back(int'(cl));
    if (ped_q.size() > 3) void'(ped_q.pop_front());
    if (car_q.size() > 3) void'(car_q.pop_front());

    if (pg && !m_pg_d) m_sb = 0;
    else if (m_pl && !m_pl_d && !pg && !m_sb) begin
      m_sb = 1;
      if (m_cnt < 255) m_cnt++;
    end
    if (cg && !m_cg_d)  m_sa = 0;
    else if (m_cl && !cg) m_sa = 1;
    m_pg_d = pg;
    m_cg_d = cg;
    m_pl_d = m_pl;

    if (s2p != m_pl) begin
      p_run++;
      if (p_run == DEB + 1) begin m_pl = s2p; p_run = 0; end
    end else p_run = 0;
    if (s2c != m_cl) begin
      c_run++;
      if (c_run == DEB + 1) begin m_cl = s2c; c_run = 0; end
    end else c_run = 0;
  endfunction

  task automatic check_all(input string tag);
    n_tests++;
    assert (sb === m_sb) else begin
      n_fail++; $error("FAIL %s sensor_b got %b want %b", tag, sb, m_sb);
    end
    n_tests++;
    assert (sa === m_sa) else begin
      n_fail++; $error("FAIL %s sensor_a got %b want %b", tag, sa, m_sa);
    end
    n_tests++;
    assert (lamp === m_sb) else begin
      n_fail++; $error("FAIL %s wait_lamp got %b want %b", tag, lamp, m_sb);
    end
    n_tests++;
    assert (cnt === 8'(m_cnt)) else begin
      n_fail++; $error("FAIL %s req_count got %0d want %0d", tag, cnt, m_cnt);
    end
  endtask

  task automatic chk1(input string tag, input logic got, input logic want);
    n_tests++;
    assert (got === want) else begin
      n_fail++; $error("FAIL %s got %b want %b", tag, got, want);
    end
  endtask

  task automatic chk8(input string tag, input logic [7:0] got, input logic [7:0] want);
    n_tests++;
    assert (got === want) else begin
      n_fail++; $error("FAIL %s got %0d want %0d", tag, got, want);
    end
  endtask

  // One clock: model sees the same inputs as the DUT edge; check mid-low phase.
  task automatic cyc(input string tag);
    @(posedge clk);
    if (rst) mreset(); else model_edge();
    @(negedge clk);
    check_all(tag);
  endtask

  task automatic cycles(input int n, input string tag);
    for (int i = 0; i < n; i++) cyc(tag);
  endtask

  initial begin
    logic [7:0] cnt_before;
    rst = 1; pb = 0; cl = 0; pg = 0; cg = 0;
    mreset();
    #1;
    check_all("reset_init");
    cycles(3, "reset_hold");
    rst = 0;
    cycles(3, "idle");

    // T1: reset in the middle of a high count, then recover with raw still high.
    pb = 1;
    cycles(4, "t1_pre");
    rst = 1;
    mreset();
    #1;
    chk1("t1_rst_sb", sb, 1'b0);
    chk1("t1_rst_sa", sa, 1'b0);
    chk1("t1_rst_lamp", lamp, 1'b0);
    chk8("t1_rst_cnt", cnt, 8'd0);
    @(negedge clk);
    cycles(2, "t1_in_rst");
    rst = 0;
    for (int e = 0; e <= 7; e++) begin
      cyc("t1_recover");
      chk1("t1_sb_timing", sb, (e >= 7) ? 1'b1 : 1'b0);
    end
    chk8("t1_cnt", cnt, 8'd1);
    pg = 1;
    cyc("t1_ack");
    chk1("t1_ack_clear", sb, 1'b0);
    pb = 0;
    cycles(10, "t1_release");
    pg = 0;
    cycles(2, "t1_idle");

    // T2: bounce shorter than the debounce window is ignored.
    pb = 1; cyc("t2");
    pb = 0; cyc("t2");
    pb = 1; cyc("t2");
    pb = 0;
    cycles(10, "t2_settle");
    chk1("t2_sb", sb, 1'b0);
    chk8("t2_cnt", cnt, 8'd1);

    // T3: clean press, request appears after edge 7, then ack clears it.
    pb = 1;
    for (int e = 0; e < 10; e++) begin
      cyc("t3_press");
      chk1("t3_sb_timing", sb, (e >= 7) ? 1'b1 : 1'b0);
    end
    chk8("t3_cnt", cnt, 8'd2);
    pg = 1;
    cyc("t3_ack");
    chk1("t3_ack_clear", sb, 1'b0);
    pb = 0;
    cycles(8, "t3_release");
    pg = 0;
    cycles(2, "t3_idle");

    // T4: level rise and ack rise on the same edge, then a press during green.
    cnt_before = cnt;
    pb = 1;
    cycles(7, "t4_press");
    pg = 1;
    cyc("t4_collide");
    chk1("t4_collide_sb", sb, 1'b0);
    cycles(3, "t4_hold");
    pb = 0;
    cycles(8, "t4_release");
    pb = 1;
    cycles(10, "t4_green_press");
    chk1("t4_green_sb", sb, 1'b0);
    chk8("t4_cnt", cnt, cnt_before);
    pb = 0;
    cycles(8, "t4_release2");
    pg = 0;
    cycles(2, "t4_idle");

    // T5: car request is level based and re-asserts after the green pulse.
    cl = 1;
    cycles(8, "t5_car");
    chk1("t5_sa_set", sa, 1'b1);
    cg = 1;
    cyc("t5_green");
    chk1("t5_sa_clr", sa, 1'b0);
    cyc("t5_green_hold");
    chk1("t5_sa_held_clr", sa, 1'b0);
    cg = 0;
    cyc("t5_green_off");
    chk1("t5_sa_reset", sa, 1'b1);
    cl = 0;
    cycles(8, "t5_release");
    cg = 1; cyc("t5_ack2");
    cg = 0; cyc("t5_idle");

    // Randomized traffic on all four inputs, checked by the model each cycle.
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 7) == 0)  pb = ~pb;
      if ($urandom_range(0, 7) == 0)  cl = ~cl;
      if ($urandom_range(0, 15) == 0) pg = ~pg;
      if ($urandom_range(0, 15) == 0) cg = ~cg;
      cyc("rand");
    end
    pb = 0; cl = 0; pg = 0; cg = 0;
    cycles(10, "rand_settle");
    pg = 1; cg = 1; cyc("rand_ack");
    pg = 0; cg = 0; cyc("rand_idle");

    // T6: many clean presses saturate the counter at 255.
    for (int k = 0; k < 300; k++) begin
      pb = 1; cycles(8, "t6_press");
      pb = 0; cycles(7, "t6_release");
      pg = 1; cyc("t6_ack");
      pg = 0; cyc("t6_idle");
    end
    chk8("t6_saturate", cnt, 8'hFF);
    chk1("t6_sb_idle", sb, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
